// File: rtl/fifo_engine_pkg.sv
// Shared types and field positions for the FIFO packet engine.
package fifo_engine_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESULT,
        STATUS
    } state_t;

    localparam logic [7:0] OP_ECHO = 8'h00;
    localparam logic [7:0] OP_SUM  = 8'h01;
    localparam logic [7:0] OP_XOR  = 8'h02;

    localparam int HDR_OP_LSB   = 24;
    localparam int HDR_LEN_W    = 16;
    localparam int STAT_OP_LSB  = 24;
    localparam int STAT_ERR_LSB = 16;

    function automatic logic is_reduce(input logic [7:0] op);
        return (op == OP_SUM) || (op == OP_XOR);
    endfunction

    function automatic logic is_drain(input logic [7:0] op);
        return (op != OP_ECHO) && !is_reduce(op);
    endfunction

    function automatic logic [31:0] pack_status(
        input logic [7:0]  op,
        input logic [7:0]  err,
        input logic [15:0] pkt
    );
        logic [31:0] w;
        w = '0;
        w[STAT_OP_LSB +: 8]  = op;
        w[STAT_ERR_LSB +: 8] = err;
        w[15:0]              = pkt;
        return w;
    endfunction

endpackage

// File: rtl/fifo_packet_engine.sv
// Pops packets from the host FIFO, echoes or reduces them into the
// user FIFO, and posts a status word to the register file per packet.
module fifo_packet_engine
    import fifo_engine_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRESSWIDTH = 32,
    parameter int CTRL_ADDR    = 2,
    parameter int STAT_ADDR    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    r_fifo_empty,
    input  logic [DATAWIDTH-1:0]    r_fifo_read_data,
    output logic                    r_fifo_read_enable,
    input  logic                    w_fifo_full,
    output logic                    w_fifo_write_enable,
    output logic [DATAWIDTH-1:0]    w_fifo_write_data,
    output logic [ADDRESSWIDTH-1:0] u_addr,
    input  logic [DATAWIDTH-1:0]    u_read_data,
    output logic                    u_write,
    output logic [DATAWIDTH-1:0]    u_write_data
);

    state_t                 state_q, state_d;
    logic [7:0]             op_q, op_d;
    logic [HDR_LEN_W-1:0]   rem_q, rem_d;
    logic [DATAWIDTH-1:0]   acc_q, acc_d;
    logic [15:0]            pkt_q, pkt_d;
    logic [7:0]             err_q, err_d;
    logic                   done;
    logic [7:0]             hdr_op;
    logic [HDR_LEN_W-1:0]   hdr_len;
    logic                   unused_ctrl;

    assign hdr_op      = r_fifo_read_data[HDR_OP_LSB +: 8];
    assign hdr_len     = r_fifo_read_data[HDR_LEN_W-1:0];
    assign unused_ctrl = ^u_read_data[DATAWIDTH-1:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        rem_d               = rem_q;
        acc_d               = acc_q;
        pkt_d               = pkt_q;
        err_d               = err_q;
        done                = 1'b0;
        r_fifo_read_enable  = 1'b0;
        w_fifo_write_enable = 1'b0;
        w_fifo_write_data   = '0;
        unique case (state_q)
            IDLE: begin
                if (u_read_data[0] && !r_fifo_empty) begin
                    r_fifo_read_enable = 1'b1;
                    op_d  = hdr_op;
                    rem_d = hdr_len;
                    acc_d = '0;
                    if (hdr_len != '0) begin
                        state_d = DATA;
                    end else if (is_reduce(hdr_op)) begin
                        state_d = RESULT;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            DATA: begin
                if (op_q == OP_ECHO) begin
                    r_fifo_read_enable  = !r_fifo_empty && !w_fifo_full;
                    w_fifo_write_enable = r_fifo_read_enable;
                    w_fifo_write_data   = r_fifo_read_data;
                end else begin
                    r_fifo_read_enable  = !r_fifo_empty;
                end
                if (r_fifo_read_enable) begin
                    if (op_q == OP_SUM) begin
                        acc_d = acc_q + r_fifo_read_data;
                    end else if (op_q == OP_XOR) begin
                        acc_d = acc_q ^ r_fifo_read_data;
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q == HDR_LEN_W'(1)) begin
                        if (is_reduce(op_q)) begin
                            state_d = RESULT;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
            end
            RESULT: begin
                w_fifo_write_data   = acc_q;
                w_fifo_write_enable = !w_fifo_full;
                done                = !w_fifo_full;
            end
            STATUS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Counts bump on the way into STATUS so the posted word is post-increment
        if (done) begin
            state_d = STATUS;
            pkt_d   = pkt_q + 16'd1;
            if (is_drain(op_d) && err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    assign u_write      = (state_q == STATUS);
    assign u_addr       = u_write ? ADDRESSWIDTH'(STAT_ADDR)
                                  : ADDRESSWIDTH'(CTRL_ADDR);
    assign u_write_data = u_write ? DATAWIDTH'(pack_status(op_q, err_q, pkt_q))
                                  : '0;

endmodule

// File: tb/tb_fifo_packet_engine.sv
// Directed bench: packet table plus stall, enable and reset sequences
// against a simple show-ahead FIFO and register-file model.
module tb_fifo_packet_engine;

    logic        clk;
    logic        reset_n;
    logic        r_fifo_empty;
    logic [31:0] r_fifo_read_data;
    logic        r_fifo_read_enable;
    logic        w_fifo_full;
    logic        w_fifo_write_enable;
    logic [31:0] w_fifo_write_data;
    logic [31:0] u_addr;
    logic [31:0] u_read_data;
    logic        u_write;
    logic [31:0] u_write_data;

    fifo_packet_engine dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .r_fifo_empty        (r_fifo_empty),
        .r_fifo_read_data    (r_fifo_read_data),
        .r_fifo_read_enable  (r_fifo_read_enable),
        .w_fifo_full         (w_fifo_full),
        .w_fifo_write_enable (w_fifo_write_enable),
        .w_fifo_write_data   (w_fifo_write_data),
        .u_addr              (u_addr),
        .u_read_data         (u_read_data),
        .u_write             (u_write),
        .u_write_data        (u_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_ptr;
    logic [9:0]  rd_ptr;
    logic        ctrl_en;
    logic [31:0] out_mem [0:255];
    int          out_cyc [0:255];
    int          out_cnt;
    logic [31:0] stat_mem [0:63];
    int          stat_cnt;
    int          viol;
    int          cyc;
    int          n_cmp;
    int          n_err;

    assign r_fifo_empty     = (wr_ptr == rd_ptr);
    assign r_fifo_read_data = mem[rd_ptr];
    assign u_read_data      = (u_addr == 32'd2) ? {31'd0, ctrl_en} : 32'd0;

    initial begin
        cyc = 0;
        out_cnt = 0;
        stat_cnt = 0;
        viol = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (r_fifo_read_enable && r_fifo_empty) viol <= viol + 1;
            if (w_fifo_write_enable && w_fifo_full) viol <= viol + 1;
            if (r_fifo_read_enable) rd_ptr <= rd_ptr + 10'd1;
            if (w_fifo_write_enable) begin
                out_mem[out_cnt] <= w_fifo_write_data;
                out_cyc[out_cnt] <= cyc;
                out_cnt <= out_cnt + 1;
            end
            if (u_write) begin
                stat_mem[stat_cnt] <= u_write_data;
                stat_cnt <= stat_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic wait_stat(input int target);
        int k;
        k = 0;
        while (stat_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("status_timeout", 32'(stat_cnt >= target), 32'd1);
    endtask

    typedef struct {
        logic [31:0]      hdr;
        int               n;
        logic [3:0][31:0] pl;
        int               nres;
        logic [3:0][31:0] res;
        logic [31:0]      stat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int b_out, b_st;
        logic [9:0] b_rd;

        tbl[0] = '{32'h0000_0003, 3,
                   {32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 3,
                   {32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
                   32'h0000_0001};
        tbl[1] = '{32'h0100_0002, 2,
                   {32'h0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFF}, 1,
                   {32'h0, 32'h0, 32'h0, 32'h0000_0001}, 32'h0100_0002};
        tbl[2] = '{32'h0200_0000, 0, '0, 1, '0, 32'h0200_0003};
        tbl[3] = '{32'h7F00_0002, 2,
                   {32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0}, 0, '0,
                   32'h7F01_0004};
        tbl[4] = '{32'h02AB_0003, 3,
                   {32'h0, 32'h0000_0001, 32'h0FF0_0FF0, 32'hF0F0_F0F0}, 1,
                   {32'h0, 32'h0, 32'h0, 32'hFF00_FF01}, 32'h0201_0005};
        tbl[5] = '{32'h0000_0000, 0, '0, 0, '0, 32'h0001_0006};

        n_cmp = 0;
        n_err = 0;
        wr_ptr = '0;
        ctrl_en = 1'b0;
        w_fifo_full = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_u_addr", u_addr, 32'd2);
        chk("rst_rd_en", 32'(r_fifo_read_enable), 32'd0);
        chk("rst_wr_en", 32'(w_fifo_write_enable), 32'd0);
        chk("rst_wdata", w_fifo_write_data, 32'd0);
        chk("rst_u_write", 32'(u_write), 32'd0);
        chk("rst_u_wdata", u_write_data, 32'd0);
        reset_n = 1'b1;
        ctrl_en = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            b_out = out_cnt;
            b_st  = stat_cnt;
            b_rd  = rd_ptr;
            push(tbl[v].hdr);
            for (int i = 0; i < tbl[v].n; i++) push(tbl[v].pl[i]);
            wait_stat(b_st + 1);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_nres", v), 32'(out_cnt - b_out),
                32'(tbl[v].nres));
            for (int i = 0; i < tbl[v].nres; i++)
                chk($sformatf("v%0d_res%0d", v, i), out_mem[b_out + i],
                    tbl[v].res[i]);
            chk($sformatf("v%0d_status", v), stat_mem[b_st], tbl[v].stat);
            chk($sformatf("v%0d_pops", v), 32'(10'(rd_ptr - b_rd)),
                32'(1 + tbl[v].n));
            if (tbl[v].hdr[31:24] == 8'h00 && tbl[v].n > 1)
                chk($sformatf("v%0d_b2b", v),
                    32'(out_cyc[b_out + tbl[v].n - 1] - out_cyc[b_out]),
                    32'(tbl[v].n - 1));
        end

        begin : stall_seq
            int k, bad;
            b_out = out_cnt;
            b_st  = stat_cnt;
            push(32'h0000_0004);
            push(32'h11);
            push(32'h22);
            push(32'h33);
            push(32'h44);
            k = 0;
            while (out_cnt - b_out < 2 && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("stall_reach", 32'(out_cnt - b_out), 32'd2);
            w_fifo_full = 1'b1;
            bad = 0;
            repeat (5) begin
                #1;
                if (r_fifo_read_enable || w_fifo_write_enable) bad++;
                @(negedge clk);
            end
            chk("stall_enables", 32'(bad), 32'd0);
            chk("stall_nopush", 32'(out_cnt - b_out), 32'd2);
            w_fifo_full = 1'b0;
            wait_stat(b_st + 1);
            @(negedge clk);
            chk("stall_o0", out_mem[b_out], 32'h11);
            chk("stall_o1", out_mem[b_out + 1], 32'h22);
            chk("stall_o2", out_mem[b_out + 2], 32'h33);
            chk("stall_o3", out_mem[b_out + 3], 32'h44);
            chk("stall_status", stat_mem[b_st], 32'h0001_0007);
        end

        ctrl_en = 1'b0;
        b_out = out_cnt;
        b_st  = stat_cnt;
        b_rd  = rd_ptr;
        push(32'h0000_0001);
        push(32'h5A5A_5A5A);
        repeat (10) @(negedge clk);
        chk("dis_nopop", 32'(10'(rd_ptr - b_rd)), 32'd0);
        chk("dis_nopush", 32'(out_cnt - b_out), 32'd0);
        ctrl_en = 1'b1;
        wait_stat(b_st + 1);
        @(negedge clk);
        chk("en_out", out_mem[b_out], 32'h5A5A_5A5A);
        chk("en_status", stat_mem[b_st], 32'h0001_0008);

        w_fifo_full = 1'b1;
        push(32'h0000_0003);
        push(32'hDEAD_0001);
        push(32'h2);
        push(32'h3);
        repeat (3) @(negedge clk);
        chk("pre_rst_wdata", w_fifo_write_data, 32'hDEAD_0001);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_u_addr", u_addr, 32'd2);
        chk("mid_rst_rd_en", 32'(r_fifo_read_enable), 32'd0);
        chk("mid_rst_wdata", w_fifo_write_data, 32'd0);
        chk("mid_rst_u_write", 32'(u_write), 32'd0);
        w_fifo_full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        b_out = out_cnt;
        b_st  = stat_cnt;
        push(32'h0100_0002);
        push(32'd5);
        push(32'd6);
        wait_stat(b_st + 1);
        @(negedge clk);
        chk("post_rst_nres", 32'(out_cnt - b_out), 32'd1);
        chk("post_rst_sum", out_mem[b_out], 32'd11);
        chk("post_rst_status", stat_mem[b_st], 32'h0100_0001);
        chk("handshake_viol", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
